decode_stage: RTL and testbench
===============================

# decode_stage

Y86-64 pipeline decode/write-back stage, directly downstream of the fetch stage. Consumes the D pipeline register, derives source and destination register IDs, and reads the 15-entry register file. Resolves operands through forwarding from execute, memory and write-back, and loads the E pipeline register. Also performs the W-stage register-file writes.

## Interface
Parameters:
- `NREG`, 15: architectural registers, IDs 0..14; ID 0xF means "none".
- `RSP_ID`, 4: stack-pointer register ID.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `D_stat` in 4, `D_icode` in 4, `D_ifun` in 4, `D_rA` in 4, `D_rB` in 4: D register fields.
- `D_valC` in 64, `D_valP` in 64: D register values.
- `E_bubble` in 1: load a nop into E this edge.
- `e_dstE` in 4, `e_valE` in 64: execute-stage result.
- `M_dstE` in 4, `M_valE` in 64, `M_dstM` in 4, `m_valM` in 64: memory-stage results.
- `W_dstE` in 4, `W_valE` in 64, `W_dstM` in 4, `W_valM` in 64: write-back ports and forwarding sources.
- `d_srcA` out 4, `d_srcB` out 4: combinational source IDs, to hazard control.
- `E_stat` out 4, `E_icode` out 4, `E_ifun` out 4: E register fields.
- `E_valC` out 64, `E_valA` out 64, `E_valB` out 64: E register values.
- `E_dstE` out 4, `E_dstM` out 4, `E_srcA` out 4, `E_srcB` out 4: E register IDs.

## Operation
- **srcA**
  - cmov, rmmov, opq, push (2,4,6,A): `D_rA`.
  - pop, ret (B,9): RSP.
  - Otherwise: F.
- **srcB**
  - opq, rmmov, mrmov (6,4,5): `D_rB`.
  - push, pop, call, ret (A,B,8,9): RSP.
  - Otherwise: F.
- **dstE**
  - cmov, irmov, opq (2,3,6): `D_rB`.
  - push, pop, call, ret: RSP.
  - Otherwise: F.
  - Condition suppression for cmov is done in execute, not here.
- **dstM**
  - mrmov, pop (5,B): `D_rA`.
  - Otherwise: F.
- **valA**
  - call and jxx (8,7) take `D_valP`.
  - Otherwise the first match on srcA wins, in this order: `e_dstE`→`e_valE`, `M_dstM`→`m_valM`, `M_dstE`→`M_valE`, `W_dstM`→`W_valM`, `W_dstE`→`W_valE`.
  - With no match, the register-file read value is used.
- **valB**: same priority chain on srcB, with no valP case.
- **ID 0xF**: never matches a forward and reads as 0.
- **Register file writes**
  - On a rising edge, `W_valE` is written to `W_dstE` and `W_valM` to `W_dstM`, each only when that ID ≠ F.
  - Both ports targeting the same register: `W_valM` wins.
- **E register load, each edge**
  - `E_bubble`=1: load the nop bubble (icode 1, ifun 0, all IDs F, vals 0, stat 1).
  - Otherwise: load `D_stat`/`D_icode`/`D_ifun`/`D_valC`, the resolved valA/valB, and dstE, dstM, srcA, srcB.
- **D_stat**: passed through unmodified, including halt/invalid (4/2/3). Decode does not alter stat.

## Timing
- `d_srcA`/`d_srcB` and operand selection are combinational from the D inputs and the forwarding inputs.
- E outputs update one rising edge after the D inputs are presented (latency 1).
- Register-file write lands on the same edge. A read in that same cycle still returns the new value through the W forwarding terms.
- **Reset** (`rst_n` low, asynchronous, also mid-run):
  - E holds the bubble values immediately: `E_icode`=1, `E_stat`=1, all IDs F, all vals 0.
  - All register-file entries are 0.
  - Held until the first rising edge after deassertion.
- There is no stall input to E. Hazard control holds D upstream and bubbles E here.

## Configuration
- `DECODE_FWD_EN` defined: full five-source forwarding as above.
- `DECODE_FWD_EN` undefined:
  - The e and M forwarding terms are removed; only the W terms and the register file remain.
  - Hazard control must stall D until the producer reaches W.
  - `d_srcA`/`d_srcB` are unchanged.

## Structure
- **Package `y86_pkg`**:
  - icode constants (HALT..POPQ);
  - `RNONE`=4'hF and `RSP`=4'h4;
  - stat codes AOK=1, ADR=3, INS=2, HLT=4;
  - the E bubble constant values.
- **Sub-module `reg_file`**:
  - 15×64 storage, async clear on `rst_n`;
  - two combinational read ports (ID F → 0);
  - two write ports with M-over-E priority.

## Test plan
- Reset mid-run: drive D with opq, pull `rst_n` low between edges → E outputs switch at once to icode 1, stat 1, IDs F, vals 0. A later read of reg 3 returns 0.
- Write-then-read: one edge with `W_dstE`=3, `W_valE`=0x1234, then D opq rA=3 rB=3 with no forwards → `E_valA`=`E_valB`=0x1234, `E_dstE`=3.
- Forward priority: `e_dstE`=2/5, `M_dstE`=2/6, `W_dstE`=2/7, D opq rA=2 → `E_valA`=5. Without `DECODE_FWD_EN` → `E_valA`=7.
- popq %rsp write conflict: `W_dstE`=4/0x100 and `W_dstM`=4/0x200 on one edge, then read RSP with no forwards → 0x200.
- call: `D_icode`=8, `D_valP`=0x40, `D_valC`=0x80 → `E_valA`=0x40, `E_srcB`=4, `E_dstE`=4, `E_dstM`=F, `d_srcA`=F.
- Bubble: valid D mrmov with `E_bubble`=1 → E loads icode 1 and IDs F. `d_srcB` still shows `D_rB`.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the decode/write-back slice: instruction codes,
// status codes, special register IDs and the E-register bubble value.
package y86_pkg;

    typedef enum logic [3:0] {
        HALT   = 4'h0,
        NOP    = 4'h1,
        CMOVXX = 4'h2,
        IRMOVQ = 4'h3,
        RMMOVQ = 4'h4,
        MRMOVQ = 4'h5,
        OPQ    = 4'h6,
        JXX    = 4'h7,
        CALL   = 4'h8,
        RET    = 4'h9,
        PUSHQ  = 4'hA,
        POPQ   = 4'hB
    } icode_e;

    typedef enum logic [3:0] {
        AOK = 4'h1,
        INS = 4'h2,
        ADR = 4'h3,
        HLT = 4'h4
    } stat_e;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        stat:  AOK,
        icode: NOP,
        ifun:  4'h0,
        valC:  64'h0,
        valA:  64'h0,
        valB:  64'h0,
        dstE:  RNONE,
        dstM:  RNONE,
        srcA:  RNONE,
        srcB:  RNONE
    };

    function automatic logic is_none(input logic [3:0] id);
        return id == RNONE;
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 15 x 64-bit Y86-64 register file: two combinational read ports (ID F reads 0)
// and two write ports where the M port overrides the E port on a shared target.
module reg_file
    import y86_pkg::*;
#(
    parameter int NREG = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rd_a_id_i,
    output logic [63:0] rd_a_data_o,
    input  logic [3:0]  rd_b_id_i,
    output logic [63:0] rd_b_data_o,
    input  logic [3:0]  wr_e_id_i,
    input  logic [63:0] wr_e_data_i,
    input  logic [3:0]  wr_m_id_i,
    input  logic [63:0] wr_m_data_i
);

    logic [63:0] mem_q [NREG];

    // The M write is issued last so it lands when both ports name one register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= 64'h0;
            end
        end else begin
            if (!is_none(wr_e_id_i)) begin
                mem_q[wr_e_id_i] <= wr_e_data_i;
            end
            if (!is_none(wr_m_id_i)) begin
                mem_q[wr_m_id_i] <= wr_m_data_i;
            end
        end
    end

    assign rd_a_data_o = is_none(rd_a_id_i) ? 64'h0 : mem_q[rd_a_id_i];
    assign rd_b_data_o = is_none(rd_b_id_i) ? 64'h0 : mem_q[rd_b_id_i];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode/write-back stage: register IDs, operand forwarding, E register.
// Define DECODE_FWD_EN for e/M forwarding; otherwise only W and the file feed operands.
module decode_stage
    import y86_pkg::*;
#(
    parameter int NREG   = 15,
    parameter int RSP_ID = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic        E_bubble,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB
);

    localparam logic [3:0] SP = 4'(RSP_ID);

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] rf_a, rf_b;
    logic [63:0] val_a, val_b;
    e_reg_t      e_d, e_q;

    reg_file #(.NREG(NREG)) u_rf (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_a_id_i   (src_a),
        .rd_a_data_o (rf_a),
        .rd_b_id_i   (src_b),
        .rd_b_data_o (rf_b),
        .wr_e_id_i   (W_dstE),
        .wr_e_data_i (W_valE),
        .wr_m_id_i   (W_dstM),
        .wr_m_data_i (W_valM)
    );

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            CMOVXX, RMMOVQ, OPQ, PUSHQ: src_a = D_rA;
            POPQ, RET:                  src_a = SP;
            default:                    src_a = RNONE;
        endcase
        case (D_icode)
            OPQ, RMMOVQ, MRMOVQ:        src_b = D_rB;
            PUSHQ, POPQ, CALL, RET:     src_b = SP;
            default:                    src_b = RNONE;
        endcase
        // cmov writes D_rB unconditionally here; execute cancels it on a false condition.
        case (D_icode)
            CMOVXX, IRMOVQ, OPQ:        dst_e = D_rB;
            PUSHQ, POPQ, CALL, RET:     dst_e = SP;
            default:                    dst_e = RNONE;
        endcase
        case (D_icode)
            MRMOVQ, POPQ:               dst_m = D_rA;
            default:                    dst_m = RNONE;
        endcase
    end

    assign d_srcA = src_a;
    assign d_srcB = src_b;

    // Youngest producer wins; W terms also cover a file write landing this same edge.
    always_comb begin
        val_a = rf_a;
        val_b = rf_b;
        if (!is_none(src_a)) begin
`ifdef DECODE_FWD_EN
            if (src_a == e_dstE)      val_a = e_valE;
            else if (src_a == M_dstM) val_a = m_valM;
            else if (src_a == M_dstE) val_a = M_valE;
            else
`endif
            if (src_a == W_dstM)      val_a = W_valM;
            else if (src_a == W_dstE) val_a = W_valE;
        end
        if (!is_none(src_b)) begin
`ifdef DECODE_FWD_EN
            if (src_b == e_dstE)      val_b = e_valE;
            else if (src_b == M_dstM) val_b = m_valM;
            else if (src_b == M_dstE) val_b = M_valE;
            else
`endif
            if (src_b == W_dstM)      val_b = W_valM;
            else if (src_b == W_dstE) val_b = W_valE;
        end
        if (D_icode == CALL || D_icode == JXX) begin
            val_a = D_valP;
        end
    end

`ifndef DECODE_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM};
`endif

    always_comb begin
        e_d       = E_BUBBLE;
        e_d.stat  = D_stat;
        e_d.icode = D_icode;
        e_d.ifun  = D_ifun;
        e_d.valC  = D_valC;
        e_d.valA  = val_a;
        e_d.valB  = val_b;
        e_d.dstE  = dst_e;
        e_d.dstM  = dst_m;
        e_d.srcA  = src_a;
        e_d.srcB  = src_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= E_BUBBLE;
        end else if (E_bubble) begin
            e_q <= E_BUBBLE;
        end else begin
            e_q <= e_d;
        end
    end

    assign E_stat  = e_q.stat;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.valC;
    assign E_valA  = e_q.valA;
    assign E_valB  = e_q.valB;
    assign E_dstE  = e_q.dstE;
    assign E_dstM  = e_q.dstM;
    assign E_srcA  = e_q.srcA;
    assign E_srcB  = e_q.srcB;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus queues the expected E register,
// a monitor pops and compares one entry after each rising edge.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        E_bubble;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    typedef struct {
        string       name;
        logic [3:0]  stat, icode, ifun, dstE, dstM, srcA, srcB;
        logic [63:0] valC, valA, valB;
    } exp_t;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mkExp(input string name, input logic [3:0] stat, input logic [3:0] icode,
                                   input logic [3:0] ifun, input logic [63:0] valC,
                                   input logic [63:0] valA, input logic [63:0] valB,
                                   input logic [3:0] dstE, input logic [3:0] dstM,
                                   input logic [3:0] srcA, input logic [3:0] srcB);
        exp_t e;
        e.name = name; e.stat = stat; e.icode = icode; e.ifun = ifun; e.valC = valC;
        e.valA = valA; e.valB = valB; e.dstE = dstE; e.dstM = dstM; e.srcA = srcA; e.srcB = srcB;
        return e;
    endfunction

    task automatic setD(input logic [3:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [3:0] rA, input logic [3:0] rB,
                        input logic [63:0] valC, input logic [63:0] valP);
        D_stat = stat; D_icode = icode; D_ifun = ifun; D_rA = rA; D_rB = rB;
        D_valC = valC; D_valP = valP;
    endtask

    task automatic clearFwd();
        e_dstE = 4'hF; e_valE = 64'h0;
        M_dstE = 4'hF; M_valE = 64'h0;
        M_dstM = 4'hF; m_valM = 64'h0;
        W_dstE = 4'hF; W_valE = 64'h0;
        W_dstM = 4'hF; W_valM = 64'h0;
    endtask

    // Queue the expected E contents, then let the edge that loads them happen.
    task automatic applyStimulus(input exp_t e);
        expQ.push_back(e);
        @(posedge clk);
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, ".icode"}, {60'h0, E_icode}, 64'h1);
        checkOutput({tag, ".stat"},  {60'h0, E_stat},  64'h1);
        checkOutput({tag, ".ifun"},  {60'h0, E_ifun},  64'h0);
        checkOutput({tag, ".dstE"},  {60'h0, E_dstE},  64'hF);
        checkOutput({tag, ".dstM"},  {60'h0, E_dstM},  64'hF);
        checkOutput({tag, ".srcA"},  {60'h0, E_srcA},  64'hF);
        checkOutput({tag, ".srcB"},  {60'h0, E_srcB},  64'hF);
        checkOutput({tag, ".valA"},  E_valA, 64'h0);
        checkOutput({tag, ".valB"},  E_valB, 64'h0);
        checkOutput({tag, ".valC"},  E_valC, 64'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput({e.name, ".stat"},  {60'h0, E_stat},  {60'h0, e.stat});
                checkOutput({e.name, ".icode"}, {60'h0, E_icode}, {60'h0, e.icode});
                checkOutput({e.name, ".ifun"},  {60'h0, E_ifun},  {60'h0, e.ifun});
                checkOutput({e.name, ".valC"},  E_valC, e.valC);
                checkOutput({e.name, ".valA"},  E_valA, e.valA);
                checkOutput({e.name, ".valB"},  E_valB, e.valB);
                checkOutput({e.name, ".dstE"},  {60'h0, E_dstE},  {60'h0, e.dstE});
                checkOutput({e.name, ".dstM"},  {60'h0, E_dstM},  {60'h0, e.dstM});
                checkOutput({e.name, ".srcA"},  {60'h0, E_srcA},  {60'h0, e.srcA});
                checkOutput({e.name, ".srcB"},  {60'h0, E_srcB},  {60'h0, e.srcB});
            end
        end
    end

    initial begin : stimulus
        logic [63:0] fwdExpA, fwdExpB;
        rst_n = 1'b1;
        E_bubble = 1'b0;
        setD(4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        clearFwd();
        #1 rst_n = 1'b0;
        #1 checkBubble("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // nop while W writes reg 3
        W_dstE = 4'h3; W_valE = 64'h1234;
        applyStimulus(mkExp("nopWrite", 1, 1, 0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF));

        @(negedge clk);
        clearFwd();
        setD(4'h1, 4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h0);
        #1 checkOutput("opq.d_srcA", {60'h0, d_srcA}, 64'h3);
        applyStimulus(mkExp("readBack", 1, 6, 0, 0, 64'h1234, 64'h1234, 4'h3, 4'hF, 4'h3, 4'h3));

        @(negedge clk);
        W_dstE = 4'h3; W_valE = 64'h55;
        setD(4'h1, 4'h6, 4'h1, 4'h3, 4'h1, 64'h0, 64'h0);
        applyStimulus(mkExp("wSameCycle", 1, 6, 1, 0, 64'h55, 64'h0, 4'h1, 4'hF, 4'h3, 4'h1));

        @(negedge clk);
        clearFwd();
        e_dstE = 4'h2; e_valE = 64'h5;
        M_dstE = 4'h2; M_valE = 64'h6;
        W_dstE = 4'h2; W_valE = 64'h7;
        setD(4'h1, 4'h6, 4'h0, 4'h2, 4'h1, 64'h0, 64'h0);
`ifdef DECODE_FWD_EN
        fwdExpA = 64'h5;
`else
        fwdExpA = 64'h7;
`endif
        applyStimulus(mkExp("fwdPrio", 1, 6, 0, 0, fwdExpA, 64'h0, 4'h1, 4'hF, 4'h2, 4'h1));

        @(negedge clk);
        clearFwd();
        M_dstM = 4'h2; m_valM = 64'h11;
        M_dstE = 4'h2; M_valE = 64'h22;
`ifdef DECODE_FWD_EN
        fwdExpB = 64'h11;
`else
        fwdExpB = 64'h7;
`endif
        applyStimulus(mkExp("memPrio", 1, 6, 0, 0, fwdExpB, 64'h0, 4'h1, 4'hF, 4'h2, 4'h1));

        @(negedge clk);
        clearFwd();
        W_dstE = 4'h4; W_valE = 64'h100;
        W_dstM = 4'h4; W_valM = 64'h200;
        setD(4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        applyStimulus(mkExp("rspConflict", 1, 1, 0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF));

        @(negedge clk);
        clearFwd();
        setD(4'h1, 4'hB, 4'h0, 4'h5, 4'hF, 64'h0, 64'h0);
        applyStimulus(mkExp("popRsp", 1, 11, 0, 0, 64'h200, 64'h200, 4'h4, 4'h5, 4'h4, 4'h4));

        @(negedge clk);
        setD(4'h1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h80, 64'h40);
        #1 checkOutput("call.d_srcA", {60'h0, d_srcA}, 64'hF);
        applyStimulus(mkExp("call", 1, 8, 0, 64'h80, 64'h40, 64'h200, 4'h4, 4'hF, 4'hF, 4'h4));

        @(negedge clk);
        E_bubble = 1'b1;
        setD(4'h1, 4'h5, 4'h0, 4'h6, 4'h7, 64'h10, 64'h0);
        #1 checkOutput("bubble.d_srcB", {60'h0, d_srcB}, 64'h7);
        checkOutput("bubble.d_srcA", {60'h0, d_srcA}, 64'hF);
        applyStimulus(mkExp("bubble", 1, 1, 0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF));

        @(negedge clk);
        E_bubble = 1'b0;
        setD(4'h4, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        applyStimulus(mkExp("haltStat", 4, 0, 0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF));

        @(negedge clk);
        setD(4'h3, 4'h4, 4'h0, 4'h1, 4'h2, 64'h8, 64'h0);
        applyStimulus(mkExp("rmmovAdr", 3, 4, 0, 64'h8, 64'h0, 64'h7, 4'hF, 4'hF, 4'h1, 4'h2));

        // Mid-run reset between edges, with a live opq held on D
        @(negedge clk);
        setD(4'h1, 4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkBubble("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkExp("afterReset", 1, 6, 0, 0, 64'h0, 64'h0, 4'h3, 4'hF, 4'h3, 4'h3));

        @(negedge clk);
        setD(4'h1, 4'hB, 4'h0, 4'h5, 4'hF, 64'h0, 64'h0);
        applyStimulus(mkExp("rspCleared", 1, 11, 0, 0, 64'h0, 64'h0, 4'h4, 4'h5, 4'h4, 4'h4));

        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
